// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter:
// control-level constants, bus widths, FSM states and grant identifiers.
package mem_bus_arbiter_pkg;

    localparam logic RstEnable    = 1'b1;
    localparam logic ChipEnable   = 1'b1;
    localparam logic ChipDisable  = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;

    localparam logic [3:0] SelAllBytes = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_DM   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

    function automatic grant_t other_port(input grant_t g);
        return (g == GNT_IF) ? GNT_DM : GNT_IF;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr2.sv
// Two-way round-robin grant selector: a lone eligible port wins outright,
// a tie goes to the port that was not granted last.
module arb_rr2
    import mem_bus_arbiter_pkg::*;
(
    input  logic   if_elig,
    input  logic   dm_elig,
    input  grant_t last_grant,
    output grant_t grant,
    output logic   valid
);

    always_comb begin
        valid = if_elig | dm_elig;
        grant = GNT_IF;
        if (if_elig && dm_elig) begin
            grant = other_port(last_grant);
        end else if (dm_elig) begin
            grant = GNT_DM;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port,
// with req/ack sequencing, wait-state tolerance and a hung-access timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = InstAddrBus,
    parameter int unsigned DATA_W  = InstBus,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [3:0]        dm_sel_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              err_o,
    output logic              stall_req_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_sel_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    arb_state_t state, state_nxt;
    grant_t     last_grant, last_grant_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic if_elig, dm_elig, gnt_valid;
    grant_t gnt_id;
    logic timed_out, busy_done;
    logic [DATA_W-1:0] done_data;

    logic              mem_ce_nxt, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [3:0]        mem_sel_nxt;
    logic [DATA_W-1:0] mem_data_nxt, if_data_nxt, dm_rdata_nxt;
    logic              if_ack_nxt, dm_ack_nxt, err_nxt;

    // A port is masked during its own ack cycle so a held request is not re-granted.
    assign if_elig = if_req_i & ~if_ack_o;
    assign dm_elig = dm_req_i & ~dm_ack_o;

    assign stall_req_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));
    assign busy_done = mem_ack_i | timed_out;

    // A real ack beats a coincident timeout; writes and timeouts return zero data.
    assign done_data = (mem_ack_i && (mem_we_o != WriteEnable)) ? mem_data_i : '0;

    arb_rr2 u_rr2 (
        .if_elig    (if_elig),
        .dm_elig    (dm_elig),
        .last_grant (last_grant),
        .grant      (gnt_id),
        .valid      (gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state      <= ARB_IDLE;
            last_grant <= GNT_IF;
            cnt        <= '0;
            mem_ce_o   <= ChipDisable;
            mem_we_o   <= WriteDisable;
            mem_addr_o <= '0;
            mem_sel_o  <= '0;
            mem_data_o <= '0;
            if_data_o  <= '0;
            dm_rdata_o <= '0;
            if_ack_o   <= 1'b0;
            dm_ack_o   <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
            mem_ce_o   <= mem_ce_nxt;
            mem_we_o   <= mem_we_nxt;
            mem_addr_o <= mem_addr_nxt;
            mem_sel_o  <= mem_sel_nxt;
            mem_data_o <= mem_data_nxt;
            if_data_o  <= if_data_nxt;
            dm_rdata_o <= dm_rdata_nxt;
            if_ack_o   <= if_ack_nxt;
            dm_ack_o   <= dm_ack_nxt;
            err_o      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    state_nxt = (gnt_id == GNT_DM) ? ARB_DM : ARB_IF;
                end
            end
            ARB_IF, ARB_DM: begin
                if (busy_done) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        mem_ce_nxt     = mem_ce_o;
        mem_we_nxt     = mem_we_o;
        mem_addr_nxt   = mem_addr_o;
        mem_sel_nxt    = mem_sel_o;
        mem_data_nxt   = mem_data_o;
        if_data_nxt    = if_data_o;
        dm_rdata_nxt   = dm_rdata_o;
        if_ack_nxt     = 1'b0;
        dm_ack_nxt     = 1'b0;
        err_nxt        = 1'b0;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;

        case (state)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    mem_ce_nxt     = ChipEnable;
                    cnt_nxt        = '0;
                    last_grant_nxt = gnt_id;
                    if (gnt_id == GNT_DM) begin
                        mem_we_nxt   = dm_we_i;
                        mem_addr_nxt = dm_addr_i;
                        mem_sel_nxt  = dm_sel_i;
                        mem_data_nxt = dm_wdata_i;
                    end else begin
                        mem_we_nxt   = WriteDisable;
                        mem_addr_nxt = if_addr_i;
                        mem_sel_nxt  = SelAllBytes;
                        mem_data_nxt = '0;
                    end
                end
            end
            ARB_IF, ARB_DM: begin
                if (busy_done) begin
                    mem_ce_nxt = ChipDisable;
                    err_nxt    = ~mem_ack_i;
                    if (state == ARB_IF) begin
                        if_ack_nxt  = 1'b1;
                        if_data_nxt = done_data;
                    end else begin
                        dm_ack_nxt   = 1'b1;
                        dm_rdata_nxt = done_data;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: mem_ce_nxt = ChipDisable;
        endcase
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported instruction/data memory between the OpenMIPS instruction-fetch port and the data (MEM-stage) port.
- Sits in the SOPC between openmips and the unified memory. It sequences each access with a req/ack handshake, tolerates variable memory wait states and times out hung accesses.
- Raises a stall request toward the pipeline controller while any port is waiting.

Parameters:
- ADDR_W, 32, address width (matches InstAddrBus)
- DATA_W, 32, data width (matches InstBus)
- TIMEOUT, 16, max cycles waiting for mem_ack_i before the access is aborted with error; must be at least 2
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset (RstEnable = 1'b1)
- if_req_i  in  1  fetch request; held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_data_o  out  DATA_W  fetched word, valid while if_ack_o=1
- if_ack_o  out  1  one-cycle fetch completion pulse
- dm_req_i  in  1  data request; held until dm_ack_o
- dm_we_i  in  1  1=write, 0=read
- dm_addr_i  in  ADDR_W  data address
- dm_sel_i  in  4  byte enables
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  read data, valid while dm_ack_o=1
- dm_ack_o  out  1  one-cycle data completion pulse
- err_o  out  1  high together with an ack pulse when that access timed out
- stall_req_o  out  1  (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational
- mem_ce_o  out  1  memory chip enable (ChipEnable)
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_sel_o  out  4  memory byte enables
- mem_data_o  out  DATA_W  memory write data
- mem_data_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion, may arrive on the first ce cycle or later

Behaviour:
- Reset:
  - All registered outputs are 0: mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o, if_data_o, dm_rdata_o, if_ack_o, dm_ack_o, err_o.
  - State = IDLE, last_grant = IF, wait counter = 0.
  - A reset asserted mid-access abandons it: no ack is issued and mem_ce_o drops the next cycle.
- States: IDLE, IF_BUSY, DM_BUSY.
- IDLE:
  - An eligible request is a port's req that is high while that port's ack_o is low. This masks the request still held during its own ack cycle.
  - Only one port eligible -> grant it.
  - Both eligible -> grant the port not equal to last_grant (round-robin). The first tie after reset goes to DM.
  - On grant:
    - Register address, sel, wdata and we into the mem_* outputs. IF grants force we=0 and sel=4'b1111.
    - Set mem_ce_o=1, clear the counter, update last_grant, and go to the matching BUSY state.
- BUSY:
  - mem_* outputs are held stable.
  - The counter increments every cycle that mem_ack_i=0.
  - mem_ack_i=1:
    - Capture mem_data_i into the granted port's data_o (for a write, data_o = 0).
    - Pulse that port's ack_o next cycle with err_o=0.
    - Drop mem_ce_o and return to IDLE.
  - Counter reaches TIMEOUT-1 with no ack -> pulse ack_o with err_o=1 and data_o=0, drop mem_ce_o, return to IDLE.
  - mem_ack_i on the same cycle as the timeout -> the ack wins and err_o=0.
- Latency:
  - Request to mem_ce_o: 1 cycle.
  - mem_ack_i to ack_o: 1 cycle.
  - Minimum request to ack is 2 cycles, with zero-wait memory acking on the first ce cycle.
- Throughput: a new grant can be issued in the same cycle as the previous ack pulse. Back-to-back accesses therefore have no idle mem_ce_o gap beyond that one cycle.
- Protocol rules:
  - mem_ack_i while in IDLE is ignored.
  - Requesters must hold their inputs stable until ack; changing them mid-access is undefined.
  - ack_o and err_o are single-cycle pulses; the data outputs hold their value until the next ack.

Decomposition:
- Shared package (defines.v additions):
  - state encodings ARB_IDLE, ARB_IF, ARB_DM
  - grant IDs GNT_IF, GNT_DM
  - reuse of RstEnable, ChipEnable, WriteEnable, InstAddrBus, InstBus
- One natural sub-module: arb_rr2, the 2-way round-robin grant selector (inputs: two eligible bits and last_grant; output: grant ID and valid).

Test Plan:
- Single fetch, zero-wait memory:
  - Stimulus: if_req_i=1, if_addr_i=0x0000_0004, mem returns 0x3401_1100 with mem_ack_i on the first ce cycle.
  - Response: mem_ce_o high 1 cycle, if_ack_o pulses 2 cycles after req, if_data_o=0x3401_1100, err_o=0.
- Data write with 3 wait states:
  - Stimulus: dm_we_i=1, addr 0x100, sel 4'b0011, wdata 0xDEAD_BEEF.
  - Response: mem_we_o=1, mem_sel_o=0011 held 4 cycles, dm_ack_o 1 cycle after mem_ack_i, stall_req_o high until the ack.
- Simultaneous requests from reset:
  - Stimulus: both ports request together from reset.
  - Response: DM is granted first, IF next. A second tie then goes to DM, and IF is never starved.
- Timeout with TIMEOUT=16:
  - Stimulus: memory never acks.
  - Response: if_ack_o and err_o pulse exactly 16 cycles after mem_ce_o rises, if_data_o=0, mem_ce_o low next cycle.
- Reset mid-access:
  - Stimulus: rst=1 during DM_BUSY.
  - Response: all outputs are 0 the next cycle, no dm_ack_o, and a fresh request after reset completes normally.
- Held request during ack:
  - Stimulus: requester keeps if_req_i high through its ack cycle, then drops it.
  - Response: no duplicate grant, exactly one memory access.
